// File: rtl/nn_pkg.sv
// Shared types and constants for the operand load / compute sequencing controller.
package nn_pkg;

    // Controller states, 2-bit encoded.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2,
        StWait = 2'd3
    } state_e;

    // Operand register targets.
    localparam logic SEL_WEIGHTS = 1'b0;
    localparam logic SEL_DATA    = 1'b1;

    // Width of the nibble index into the largest operand register.
    localparam int unsigned IDX_W = 5;

    // Width of the compute timeout timer (TIMEOUT is at most 255).
    localparam int unsigned TMR_W = 8;

    // Write write/index record packed for convenient comparison.
    typedef struct packed {
        logic             sel;
        logic [IDX_W-1:0] idx;
        logic [3:0]       nib;
    } wr_rec_t;

endpackage

// File: rtl/nn_load_ctrl_if.sv
// Handshake and operand-register bus between host/pin decoder, controller and datapath.
interface nn_load_ctrl_if;
    import nn_pkg::*;

    // Host load / run requests
    logic             load_req;
    logic             load_sel;
    logic             abort;
    logic             in_valid;
    logic [3:0]       in_nibble;
    logic             in_ready;
    logic             run_req;

    // Datapath handshake
    logic             compute_done;
    logic             compute_start;

    // Operand register write port
    logic             reg_wr_en;
    logic             reg_sel;
    logic [IDX_W-1:0] reg_idx;
    logic [3:0]       reg_nib;

    // Status
    logic             load_done;
    logic             run_done;
    logic             err;
    logic             w_loaded;
    logic             d_loaded;

    // Host / datapath side: drives requests, observes status.
    modport master (
        output load_req,
        output load_sel,
        output abort,
        output in_valid,
        output in_nibble,
        output run_req,
        output compute_done,
        input  in_ready,
        input  compute_start,
        input  reg_wr_en,
        input  reg_sel,
        input  reg_idx,
        input  reg_nib,
        input  load_done,
        input  run_done,
        input  err,
        input  w_loaded,
        input  d_loaded
    );

    // Controller side.
    modport slave (
        input  load_req,
        input  load_sel,
        input  abort,
        input  in_valid,
        input  in_nibble,
        input  run_req,
        input  compute_done,
        output in_ready,
        output compute_start,
        output reg_wr_en,
        output reg_sel,
        output reg_idx,
        output reg_nib,
        output load_done,
        output run_done,
        output err,
        output w_loaded,
        output d_loaded
    );

endinterface

// File: rtl/nibble_counter.sv
// Loadable counter with a terminal-count compare; counts up or down by one per enable.
module nibble_counter #(
    parameter int unsigned WIDTH = 5,
    parameter bit          DOWN  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] value,
    output logic             tc
);

    localparam logic [WIDTH-1:0] Step = WIDTH'(1);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Next count: load wins over counting.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (en) begin
            value_d = DOWN ? (value_q - Step) : (value_q + Step);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign tc    = (value_q == term);

endmodule

// File: rtl/nn_load_ctrl.sv
// Operand load sequencer and compute-pass supervisor. Streams host nibbles MSB-first into
// the weight or data register, tracks which operands are complete, and launches a single
// compute pass with a timeout once both are loaded.
module nn_load_ctrl
    import nn_pkg::*;
#(
    parameter int unsigned WEIGHT_BITS = 32,
    parameter int unsigned DATA_BITS   = 128,
    parameter int unsigned TIMEOUT     = 255
) (
    input logic          clk,
    input logic          rst,
    nn_load_ctrl_if.slave bus
);

    localparam int unsigned NW = WEIGHT_BITS / 4;
    localparam int unsigned ND = DATA_BITS / 4;

    localparam logic [IDX_W-1:0] W_LAST = IDX_W'(NW - 1);
    localparam logic [IDX_W-1:0] D_LAST = IDX_W'(ND - 1);

    state_e state_q, state_d;

    logic             sel_q, sel_d;
    logic             w_loaded_q, w_loaded_d;
    logic             d_loaded_q, d_loaded_d;
    logic             wr_en_q, wr_en_d;
    logic             reg_sel_q, reg_sel_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       nib_q, nib_d;
    logic             load_done_q, load_done_d;
    logic             run_done_q, run_done_d;
    logic             err_q, err_d;

    // Nibble counter and timeout timer controls
    logic             cnt_load, cnt_en, cnt_tc;
    logic [IDX_W-1:0] cnt_value;
    logic [IDX_W-1:0] last_idx;
    logic             tmr_load, tmr_en, tmr_tc;
    logic [TMR_W-1:0] tmr_value;
    logic             timed_out;

    assign last_idx = (sel_q == SEL_DATA) ? D_LAST : W_LAST;

    nibble_counter #(
        .WIDTH (IDX_W),
        .DOWN  (1'b0)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val ('0),
        .en       (cnt_en),
        .term     (last_idx),
        .value    (cnt_value),
        .tc       (cnt_tc)
    );

    nibble_counter #(
        .WIDTH (TMR_W),
        .DOWN  (1'b1)
    ) u_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (TMR_W'(TIMEOUT)),
        .en       (tmr_en),
        .term     (TMR_W'(1)),
        .value    (tmr_value),
        .tc       (tmr_tc)
    );

    // The zero test keeps a misconfigured TIMEOUT of 0 from wrapping into a long wait.
    assign timed_out = tmr_tc || (tmr_value == '0);

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        w_loaded_d  = w_loaded_q;
        d_loaded_d  = d_loaded_q;
        wr_en_d     = 1'b0;
        reg_sel_d   = reg_sel_q;
        idx_d       = idx_q;
        nib_d       = nib_q;
        load_done_d = 1'b0;
        run_done_d  = 1'b0;
        err_d       = 1'b0;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
        tmr_load    = 1'b0;
        tmr_en      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.load_req) begin
                    sel_d    = bus.load_sel;
                    cnt_load = 1'b1;
                    if (bus.load_sel == SEL_DATA) begin
                        d_loaded_d = 1'b0;
                    end else begin
                        w_loaded_d = 1'b0;
                    end
                    state_d = StLoad;
                end else if (bus.run_req) begin
                    if (w_loaded_q && d_loaded_q) begin
                        state_d = StRun;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            StLoad: begin
                // Abort beats a simultaneous nibble: no write, flag stays clear.
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (bus.in_valid) begin
                    wr_en_d   = 1'b1;
                    reg_sel_d = sel_q;
                    idx_d     = last_idx - cnt_value;
                    nib_d     = bus.in_nibble;
                    cnt_en    = 1'b1;
                    if (cnt_tc) begin
                        if (sel_q == SEL_DATA) begin
                            d_loaded_d = 1'b1;
                        end else begin
                            w_loaded_d = 1'b1;
                        end
                        load_done_d = 1'b1;
                        state_d     = StIdle;
                    end
                end
            end

            StRun: begin
                tmr_load = 1'b1;
                state_d  = StWait;
            end

            StWait: begin
                if (bus.compute_done) begin
                    run_done_d = 1'b1;
                    state_d    = StIdle;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs; reset clears everything including the loaded flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sel_q       <= SEL_WEIGHTS;
            w_loaded_q  <= 1'b0;
            d_loaded_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            reg_sel_q   <= 1'b0;
            idx_q       <= '0;
            nib_q       <= '0;
            load_done_q <= 1'b0;
            run_done_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            w_loaded_q  <= w_loaded_d;
            d_loaded_q  <= d_loaded_d;
            wr_en_q     <= wr_en_d;
            reg_sel_q   <= reg_sel_d;
            idx_q       <= idx_d;
            nib_q       <= nib_d;
            load_done_q <= load_done_d;
            run_done_q  <= run_done_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready      = (state_q == StLoad);
    assign bus.compute_start = (state_q == StRun);
    assign bus.reg_wr_en     = wr_en_q;
    assign bus.reg_sel       = reg_sel_q;
    assign bus.reg_idx       = idx_q;
    assign bus.reg_nib       = nib_q;
    assign bus.load_done     = load_done_q;
    assign bus.run_done      = run_done_q;
    assign bus.err           = err_q;
    assign bus.w_loaded      = w_loaded_q;
    assign bus.d_loaded      = d_loaded_q;

endmodule

// File: tb/tb_nn_load_ctrl.sv
// Bench for nn_load_ctrl: two instances (default TIMEOUT and TIMEOUT=4) share one stimulus
// stream; operand writes are checked against a scoreboard queue per instance.
module tb_nn_load_ctrl;
    import nn_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_req, load_sel, abort, in_valid, run_req, compute_done;
    logic [3:0] in_nibble;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt_a = 0;
    int wr_cnt_b = 0;
    int base_a, base_b;

    wr_rec_t q_a[$];
    wr_rec_t q_b[$];
    wr_rec_t ea, eb;

    nn_load_ctrl_if ia ();
    nn_load_ctrl_if ib ();

    assign ia.load_req     = load_req;
    assign ia.load_sel     = load_sel;
    assign ia.abort        = abort;
    assign ia.in_valid     = in_valid;
    assign ia.in_nibble    = in_nibble;
    assign ia.run_req      = run_req;
    assign ia.compute_done = compute_done;
    assign ib.load_req     = load_req;
    assign ib.load_sel     = load_sel;
    assign ib.abort        = abort;
    assign ib.in_valid     = in_valid;
    assign ib.in_nibble    = in_nibble;
    assign ib.run_req      = run_req;
    assign ib.compute_done = compute_done;

    nn_load_ctrl dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia)
    );

    nn_load_ctrl #(
        .TIMEOUT (4)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       load_req;
        logic       load_sel;
        logic       in_valid;
        logic [3:0] nib;
        logic       exp_acc;
        logic [4:0] exp_idx;
        logic       exp_ready;
        logic       exp_wr;
        logic       exp_done;
        logic       exp_wl;
    } vec_t;

    vec_t vecs[10];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        load_req     = 1'b0;
        load_sel     = 1'b0;
        abort        = 1'b0;
        in_valid     = 1'b0;
        in_nibble    = 4'h0;
        run_req      = 1'b0;
        compute_done = 1'b0;
    endtask

    task automatic push_wr(input logic sel, input logic [4:0] idx, input logic [3:0] nib);
        wr_rec_t w;
        w = {sel, idx, nib};
        q_a.push_back(w);
        q_b.push_back(w);
    endtask

    function automatic logic [3:0] dnib(input int k);
        return 4'((k * 5 + 1) % 16);
    endfunction

    task automatic chk_zero(input string tag);
        chk1({tag, " a.in_ready"}, ia.in_ready, 1'b0);
        chk1({tag, " a.reg_wr_en"}, ia.reg_wr_en, 1'b0);
        chk1({tag, " a.reg_sel"}, ia.reg_sel, 1'b0);
        chk({tag, " a.reg_idx"}, 32'(ia.reg_idx), 32'd0);
        chk({tag, " a.reg_nib"}, 32'(ia.reg_nib), 32'd0);
        chk1({tag, " a.compute_start"}, ia.compute_start, 1'b0);
        chk1({tag, " a.load_done"}, ia.load_done, 1'b0);
        chk1({tag, " a.run_done"}, ia.run_done, 1'b0);
        chk1({tag, " a.err"}, ia.err, 1'b0);
        chk1({tag, " a.w_loaded"}, ia.w_loaded, 1'b0);
        chk1({tag, " a.d_loaded"}, ia.d_loaded, 1'b0);
        chk1({tag, " b.in_ready"}, ib.in_ready, 1'b0);
        chk1({tag, " b.reg_wr_en"}, ib.reg_wr_en, 1'b0);
        chk1({tag, " b.reg_sel"}, ib.reg_sel, 1'b0);
        chk({tag, " b.reg_idx"}, 32'(ib.reg_idx), 32'd0);
        chk({tag, " b.reg_nib"}, 32'(ib.reg_nib), 32'd0);
        chk1({tag, " b.compute_start"}, ib.compute_start, 1'b0);
        chk1({tag, " b.err"}, ib.err, 1'b0);
        chk1({tag, " b.w_loaded"}, ib.w_loaded, 1'b0);
        chk1({tag, " b.d_loaded"}, ib.d_loaded, 1'b0);
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (ia.reg_wr_en) begin
            wr_cnt_a++;
            if (q_a.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wr_a unexpected: got 0x%0h, expected no write",
                         {ia.reg_sel, ia.reg_idx, ia.reg_nib});
            end else begin
                ea = q_a.pop_front();
                chk("wr_a", 32'({ia.reg_sel, ia.reg_idx, ia.reg_nib}), 32'(ea));
            end
        end
        if (ib.reg_wr_en) begin
            wr_cnt_b++;
            if (q_b.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wr_b unexpected: got 0x%0h, expected no write",
                         {ib.reg_sel, ib.reg_idx, ib.reg_nib});
            end else begin
                eb = q_b.pop_front();
                chk("wr_b", 32'({ib.reg_sel, ib.reg_idx, ib.reg_nib}), 32'(eb));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Weight-load table: load_req, then nibbles 1..8 back to back, then one idle cycle.
        vecs[0] = '{1'b1, SEL_WEIGHTS, 1'b0, 4'h0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 1; k <= 8; k++) begin
            vecs[k] = '{1'b0, 1'b0, 1'b1, 4'(k), 1'b1, 5'(8 - k), (k < 8), 1'b1, (k == 8),
                        (k == 8)};
        end
        vecs[9] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1};

        clear_in();
        rst = 1'b1;
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;

        // Weight load
        for (int i = 0; i < 10; i++) begin
            load_req  = vecs[i].load_req;
            load_sel  = vecs[i].load_sel;
            in_valid  = vecs[i].in_valid;
            in_nibble = vecs[i].nib;
            if (vecs[i].exp_acc) push_wr(SEL_WEIGHTS, vecs[i].exp_idx, vecs[i].nib);
            tick();
            clear_in();
            chk1($sformatf("wl[%0d] a.in_ready", i), ia.in_ready, vecs[i].exp_ready);
            chk1($sformatf("wl[%0d] a.reg_wr_en", i), ia.reg_wr_en, vecs[i].exp_wr);
            chk1($sformatf("wl[%0d] a.load_done", i), ia.load_done, vecs[i].exp_done);
            chk1($sformatf("wl[%0d] a.w_loaded", i), ia.w_loaded, vecs[i].exp_wl);
            chk1($sformatf("wl[%0d] b.w_loaded", i), ib.w_loaded, vecs[i].exp_wl);
        end
        chk("wl strobes a", 32'(wr_cnt_a), 32'd8);

        // Early run with only weights loaded
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        chk1("early a.err", ia.err, 1'b1);
        chk1("early b.err", ib.err, 1'b1);
        chk1("early a.compute_start", ia.compute_start, 1'b0);
        tick();
        chk1("early+1 a.err", ia.err, 1'b0);
        chk1("early+1 a.compute_start", ia.compute_start, 1'b0);

        // load_req beats run_req; this starts the gapped data load
        run_req  = 1'b1;
        load_req = 1'b1;
        load_sel = SEL_DATA;
        tick();
        clear_in();
        chk1("prio a.in_ready", ia.in_ready, 1'b1);
        chk1("prio a.compute_start", ia.compute_start, 1'b0);
        chk1("prio a.err", ia.err, 1'b0);
        base_a = wr_cnt_a;
        base_b = wr_cnt_b;
        for (int k = 0; k < 32; k++) begin
            in_valid = 1'b0;
            tick();
            in_valid  = 1'b1;
            in_nibble = dnib(k);
            push_wr(SEL_DATA, 5'(31 - k), dnib(k));
            tick();
            in_valid = 1'b0;
            if (k == 15) begin
                chk1("dgap mid a.in_ready", ia.in_ready, 1'b1);
                chk1("dgap mid a.d_loaded", ia.d_loaded, 1'b0);
            end else if (k == 31) begin
                chk1("dgap end a.load_done", ia.load_done, 1'b1);
                chk1("dgap end a.d_loaded", ia.d_loaded, 1'b1);
                chk1("dgap end a.in_ready", ia.in_ready, 1'b0);
            end
        end
        tick();
        chk1("dgap end+1 a.load_done", ia.load_done, 1'b0);
        chk("dgap strobes a", 32'(wr_cnt_a - base_a), 32'd32);
        chk("dgap strobes b", 32'(wr_cnt_b - base_b), 32'd32);

        // Run: compute_done 5 cycles after compute_start; instance b times out first
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        chk1("run a.compute_start", ia.compute_start, 1'b1);
        chk1("run b.compute_start", ib.compute_start, 1'b1);
        for (int n = 1; n <= 4; n++) begin
            tick();
            chk1($sformatf("run+%0d a.compute_start", n), ia.compute_start, 1'b0);
            chk1($sformatf("run+%0d b.err", n), ib.err, 1'b0);
        end
        tick();
        chk1("run+5 b.err", ib.err, 1'b1);
        chk1("run+5 a.err", ia.err, 1'b0);
        chk1("run+5 a.run_done", ia.run_done, 1'b0);
        compute_done = 1'b1;
        tick();
        compute_done = 1'b0;
        chk1("run+6 a.run_done", ia.run_done, 1'b1);
        chk1("run+6 a.err", ia.err, 1'b0);
        chk1("run+6 b.run_done", ib.run_done, 1'b0);
        chk1("run+6 b.err", ib.err, 1'b0);
        tick();
        chk1("run+7 a.run_done", ia.run_done, 1'b0);
        chk1("run+7 a.w_loaded", ia.w_loaded, 1'b1);
        chk1("run+7 a.d_loaded", ia.d_loaded, 1'b1);

        // Abort after three data nibbles, with a nibble presented on the abort cycle
        load_req = 1'b1;
        load_sel = SEL_DATA;
        tick();
        clear_in();
        base_a = wr_cnt_a;
        for (int k = 0; k < 3; k++) begin
            in_valid  = 1'b1;
            in_nibble = 4'(k + 9);
            push_wr(SEL_DATA, 5'(31 - k), 4'(k + 9));
            tick();
        end
        abort     = 1'b1;
        in_valid  = 1'b1;
        in_nibble = 4'hf;
        tick();
        clear_in();
        chk1("abort a.reg_wr_en", ia.reg_wr_en, 1'b0);
        chk1("abort a.in_ready", ia.in_ready, 1'b0);
        chk1("abort a.d_loaded", ia.d_loaded, 1'b0);
        chk1("abort a.load_done", ia.load_done, 1'b0);
        tick();
        chk("abort strobes a", 32'(wr_cnt_a - base_a), 32'd3);
        chk1("abort+1 a.w_loaded", ia.w_loaded, 1'b1);

        // Reload data without gaps, run, then reset in the middle of WAIT
        load_req = 1'b1;
        load_sel = SEL_DATA;
        tick();
        clear_in();
        for (int k = 0; k < 32; k++) begin
            in_valid  = 1'b1;
            in_nibble = dnib(k);
            push_wr(SEL_DATA, 5'(31 - k), dnib(k));
            tick();
        end
        in_valid = 1'b0;
        chk1("reload a.d_loaded", ia.d_loaded, 1'b1);
        tick();
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        chk1("rerun a.compute_start", ia.compute_start, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk_zero("rst_wait");
        rst = 1'b0;
        tick();
        chk_zero("after_rst");
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        chk1("post_rst a.err", ia.err, 1'b1);
        chk1("post_rst a.compute_start", ia.compute_start, 1'b0);
        tick();

        chk("sb a drained", 32'(q_a.size()), 32'd0);
        chk("sb b drained", 32'(q_b.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
